// File: rtl/genram.sv
// genram: byte-addressable RAM. The read port is pin-compatible with genrom;
// a valid/ready store port writes 1..2**EXTRA bytes little-endian.
// Build option GENRAM_WIDE_WRITE_EN: write all bytes of a store on the
// acceptance edge instead of one byte per cycle.
module genram #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int EXTRA = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW:0]             addr,
  input  logic [EXTRA-1:0]        extra,
  input  logic [AW:0]             lower_bound,
  input  logic [AW:0]             upper_bound,
  output logic [(2**EXTRA)*8-1:0] data,
  output logic                    error,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW:0]             wr_addr,
  input  logic [EXTRA-1:0]        wr_extra,
  input  logic [(2**EXTRA)*8-1:0] wr_data,
  output logic                    wr_done,
  output logic                    wr_error
);

  localparam int AB    = AW + 1;
  localparam int DEPTH = 2 ** AB;
  localparam int NB    = 2 ** EXTRA;
  localparam int BW    = NB * 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    mem [DEPTH];
  logic             accept;
  logic             wr_oob;
  logic             err_q;
  logic [BW-1:0]    rd_data_d;
  logic             rd_err_d;

`ifndef GENRAM_WIDE_WRITE_EN
  logic [AW:0]      wa_q;
  logic [EXTRA-1:0] wx_q;
  logic [BW-1:0]    wd_q;
  logic [EXTRA-1:0] cnt_q;
  logic [DW-1:0]    wr_byte;
`endif

  // Last byte is computed wide enough that addr+extra never wraps.
  function automatic logic out_of_bounds(input logic [AW:0]      a,
                                         input logic [EXTRA-1:0] x,
                                         input logic [AW:0]      lb,
                                         input logic [AW:0]      ub);
    logic [31:0] last;
    last = 32'(a) + 32'(x);
    return (a < lb) || (last > 32'(ub)) || (last >= 32'(DEPTH));
  endfunction

  assign accept   = wr_valid && wr_ready;
  assign wr_oob   = out_of_bounds(wr_addr, wr_extra, lower_bound, upper_bound);
  assign wr_ready = (state_q == IDLE) && !reset;
  assign wr_done  = (state_q == DONE) && !reset;
  assign wr_error = (state_q == DONE) && err_q && !reset;

  // Read path: bounds check and byte gather, registered below.
  always_comb begin
    rd_err_d  = out_of_bounds(addr, extra, lower_bound, upper_bound);
    rd_data_d = '0;
    if (!rd_err_d) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (EXTRA'(i) <= extra) begin
          rd_data_d[i*DW +: DW] = mem[addr + AB'(i)];
        end
      end
    end
  end

  // Read output register, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      error <= 1'b0;
    end else begin
      data  <= rd_data_d;
      error <= rd_err_d;
    end
  end

  // Store FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef GENRAM_WIDE_WRITE_EN
          state_d = DONE;
`else
          state_d = wr_oob ? DONE : BUSY;
`endif
        end
      end
`ifndef GENRAM_WIDE_WRITE_EN
      BUSY: begin
        if (cnt_q == wx_q) begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store FSM state and latched error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= wr_oob;
      end
    end
  end

`ifdef GENRAM_WIDE_WRITE_EN
  // Whole store lands on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && !wr_oob) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (EXTRA'(i) <= wr_extra) begin
          mem[wr_addr + AB'(i)] <= wr_data[i*DW +: DW];
        end
      end
    end
  end
`else
  // Request latch and byte counter; the request is held for the whole store.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      wa_q  <= wr_addr;
      wx_q  <= wr_extra;
      wd_q  <= wr_data;
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Select the byte of the latched value that the counter points at.
  always_comb begin
    wr_byte = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (cnt_q == EXTRA'(i)) begin
        wr_byte = wd_q[i*DW +: DW];
      end
    end
  end

  // One byte per BUSY cycle; reset mid-store stops further writes.
  always_ff @(posedge clk) begin
    if ((state_q == BUSY) && !reset) begin
      mem[wa_q + AB'(cnt_q)] <= wr_byte;
    end
  end
`endif

endmodule
